// File: rtl/cla_sub_pipe_if.sv
// Handshake bus for cla_sub_pipe: operand side (in_*, a, b, bin) and result side
// (out_*, diff, bout, ovf). The slave modport is the subtractor, the master its user.
interface cla_sub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/cla_sub_pipe.sv
// Pipelined a - b - bin: one 4-bit borrow-look-ahead slice per register stage,
// the inter-slice borrow travels through the stage registers; global stall on out_ready.
module cla_sub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  cla_sub_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / 4;

  // Returns {borrow_out, diff[3:0]} with every in-slice borrow computed in parallel.
  function automatic logic [4:0] bla4(input logic [3:0] x, input logic [3:0] y, input logic bs);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] br;
    g     = ~x & y;
    p     = ~(x ^ y);
    br[0] = bs;
    br[1] = g[0] | (p[0] & bs);
    br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bs);
    br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bs);
    br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & bs);
    return {br[4], x ^ y ^ br[3:0]};
  endfunction

  logic en;
  logic ovf_p;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operands entering stage k only carry the slices not yet consumed (k..STAGES-1).
    localparam int HW = WIDTH - 4 * k;

    logic [HW-1:0]    a_s;
    logic [HW-1:0]    b_s;
    logic [WIDTH-1:0] d_s;
    logic [WIDTH-1:0] d_n;
    logic             bs_s;
    logic             v_s;
    logic [4:0]       r_s;
    logic             vld_p;
    logic [WIDTH-1:0] dif_p;
    logic             brw_p;

    if (k == 0) begin : g_src
      assign a_s  = bus.a;
      assign b_s  = bus.b;
      assign d_s  = '0;
      assign bs_s = bus.bin;
      assign v_s  = bus.in_valid;
    end else begin : g_src
      assign a_s  = g_stage[k-1].g_reg.opa_p;
      assign b_s  = g_stage[k-1].g_reg.opb_p;
      assign d_s  = g_stage[k-1].dif_p;
      assign bs_s = g_stage[k-1].brw_p;
      assign v_s  = g_stage[k-1].vld_p;
    end

    assign r_s = bla4(a_s[3:0], b_s[3:0], bs_s);

    always_comb begin
      d_n          = d_s;
      d_n[4*k +: 4] = r_s[3:0];
    end

    // ---- stage k register boundary ----
    always_ff @(posedge clk or posedge rst) begin
      if (rst)     vld_p <= 1'b0;
      else if (en) vld_p <= v_s;
    end

    if (k == STAGES - 1) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dif_p <= '0;
          brw_p <= 1'b0;
          ovf_p <= 1'b0;
        end else if (en) begin
          dif_p <= d_n;
          brw_p <= r_s[4];
          ovf_p <= (a_s[3] ^ b_s[3]) & (d_n[WIDTH-1] ^ a_s[3]);
        end
      end
    end else begin : g_reg
      logic [HW-5:0] opa_p;
      logic [HW-5:0] opb_p;
      always_ff @(posedge clk) begin
        if (en) begin
          dif_p <= d_n;
          brw_p <= r_s[4];
          opa_p <= a_s[HW-1:4];
          opb_p <= b_s[HW-1:4];
        end
      end
    end
  end

  assign en            = ~g_stage[STAGES-1].vld_p | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = g_stage[STAGES-1].vld_p;
  assign bus.diff      = g_stage[STAGES-1].dif_p;
  assign bus.bout      = g_stage[STAGES-1].brw_p;
  assign bus.ovf       = ovf_p;
endmodule

// File: tb/tb_cla_sub_pipe.sv
// Bench for cla_sub_pipe: directed vectors, stall/reset scenarios and a random
// stream on WIDTH=16 and WIDTH=4 instances, scored against an arithmetic model.
module tb_cla_sub_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_sub_pipe_if #(.WIDTH(4))  f4 ();
  cla_sub_pipe_if #(.WIDTH(16)) f16 ();

  cla_sub_pipe #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(f4));
  cla_sub_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(f16));

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  exp_t        q4[$];
  exp_t        q16[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_out[2];
  logic        hold[2];
  logic [17:0] hv[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Arithmetic reference: diff modulo 2^w, unsigned borrow, sign-rule overflow.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic bi);
    exp_t        e;
    int unsigned m, av, bv, full;
    m    = (32'd1 << w) - 1;
    av   = a & m;
    bv   = b & m;
    full = av - bv - {31'd0, bi};
    e.d  = 16'(full & m);
    e.bo = (av < bv + {31'd0, bi});
    e.ov = (av[w-1] != bv[w-1]) && (e.d[w-1] != av[w-1]);
    return e;
  endfunction

  task automatic score(input int id);
    logic ov, ordy, iv, ird, bi, bo, of;
    logic [15:0] a, b, d;
    exp_t e;
    int w;
    if (id == 0) begin
      w = 4; ov = f4.out_valid; ordy = f4.out_ready; iv = f4.in_valid; ird = f4.in_ready;
      bi = f4.bin; bo = f4.bout; of = f4.ovf;
      a = {12'h0, f4.a}; b = {12'h0, f4.b}; d = {12'h0, f4.diff};
    end else begin
      w = 16; ov = f16.out_valid; ordy = f16.out_ready; iv = f16.in_valid; ird = f16.in_ready;
      bi = f16.bin; bo = f16.bout; of = f16.ovf;
      a = f16.a; b = f16.b; d = f16.diff;
    end
    if (hold[id])
      chk($sformatf("hold_w%0d", w), {13'h0, ov, d, bo, of}, {13'h0, 1'b1, hv[id]});
    hold[id] = ov && !ordy;
    hv[id]   = {d, bo, of};
    if (ov && ordy) begin
      if ((id == 0 && q4.size() == 0) || (id == 1 && q16.size() == 0)) begin
        chk($sformatf("spurious_w%0d", w), {31'h0, ov}, 32'h0);
      end else begin
        if (id == 0) e = q4.pop_front();
        else         e = q16.pop_front();
        n_out[id]++;
        chk($sformatf("result_w%0d", w), {14'h0, d, bo, of}, {14'h0, e.d, e.bo, e.ov});
      end
    end
    if (iv && ird) begin
      e = model(w, a, b, bi);
      if (id == 0) q4.push_back(e);
      else         q16.push_back(e);
    end
  endtask

  task automatic finish_cycle();
    score(0);
    score(1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ov16"}, f16.out_valid, 0);
    chk({tag, "_diff16"}, f16.diff, 0);
    chk({tag, "_bout16"}, f16.bout, 0);
    chk({tag, "_ovf16"}, f16.ovf, 0);
    chk({tag, "_ird16"}, f16.in_ready, 1);
    chk({tag, "_ov4"}, f4.out_valid, 0);
    chk({tag, "_diff4"}, f4.diff, 0);
    chk({tag, "_ird4"}, f4.in_ready, 1);
  endtask

  // One operand set into an empty WIDTH=16 pipe; result must appear exactly 4 cycles later.
  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic bi,
                         input logic [15:0] ed, input logic ebo, input logic eov);
    f16.a = a; f16.b = b; f16.bin = bi; f16.in_valid = 1'b1; f16.out_ready = 1'b1;
    @(negedge clk);
    chk("accept_ready", f16.in_ready, 1);
    finish_cycle();
    f16.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat%0d_valid_%h_%h", k, a, b), f16.out_valid, k == 4);
      if (k == 4) begin
        chk($sformatf("diff_%h_%h", a, b), f16.diff, ed);
        chk($sformatf("bout_%h_%h", a, b), f16.bout, ebo);
        chk($sformatf("ovf_%h_%h", a, b), f16.ovf, eov);
      end
      finish_cycle();
    end
  endtask

  logic [15:0] opa[8];
  logic [15:0] opb[8];
  logic        opc[8];
  int          idx;
  int          base;

  initial begin
    n_out = '{0, 0};
    hold  = '{1'b0, 1'b0};
    hv    = '{18'h0, 18'h0};
    rst = 1'b1;
    f4.in_valid = 1'b0;  f4.a = '0;  f4.b = '0;  f4.bin = 1'b0;  f4.out_ready = 1'b0;
    f16.in_valid = 1'b0; f16.a = '0; f16.b = '0; f16.bin = 1'b0; f16.out_ready = 1'b0;
    #2;
    check_idle("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    f4.out_ready = 1'b1;
    f16.out_ready = 1'b1;

    run_one(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_one(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_one(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_one(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_one(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

    // WIDTH=4: single stage, result one cycle after acceptance
    f4.a = 4'h9; f4.b = 4'h3; f4.bin = 1'b1; f4.in_valid = 1'b1;
    @(negedge clk);
    finish_cycle();
    f4.in_valid = 1'b0;
    @(negedge clk);
    chk("w4_lat1_valid", f4.out_valid, 1);
    chk("w4_diff", f4.diff, 4'h5);
    chk("w4_bout", f4.bout, 0);
    chk("w4_ovf", f4.ovf, 1);
    finish_cycle();

    // Eight back-to-back operand sets, out_ready low in cycles 5..7
    for (int i = 0; i < 8; i++) begin
      opa[i] = 16'($urandom); opb[i] = 16'($urandom); opc[i] = 1'($urandom);
    end
    idx  = 0;
    base = n_out[1];
    for (int c = 1; c <= 40 && (idx < 8 || q16.size() != 0); c++) begin
      f16.out_ready = !(c >= 5 && c <= 7);
      f16.in_valid  = (idx < 8);
      f16.a = opa[idx % 8]; f16.b = opb[idx % 8]; f16.bin = opc[idx % 8];
      @(negedge clk);
      if (c <= 12) chk($sformatf("stall_in_ready_c%0d", c), f16.in_ready, !(c >= 5 && c <= 7));
      if (f16.in_valid && f16.in_ready) idx++;
      finish_cycle();
    end
    f16.in_valid = 1'b0;
    f16.out_ready = 1'b1;
    chk("stall_accepted", idx, 8);
    chk("stall_delivered", n_out[1] - base, 8);

    // Async reset with results in flight and one held at the output
    f16.a = 16'h7FFF; f16.b = 16'hFFFF; f16.bin = 1'b0; f16.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      f16.out_ready = (i < 4);
      @(negedge clk);
      finish_cycle();
    end
    #2;
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    q4.delete();
    q16.delete();
    hold = '{1'b0, 1'b0};
    f16.in_valid = 1'b0;
    f16.out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("no_stale_%0d", i), f16.out_valid, 0);
      finish_cycle();
    end
    run_one(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Random traffic on both widths
    n_out = '{0, 0};
    for (int c = 0; c < 60000 && (n_out[0] < 10000 || n_out[1] < 10000); c++) begin
      f4.in_valid  = ($urandom_range(0, 3) != 0);
      f4.a = 4'($urandom); f4.b = 4'($urandom); f4.bin = 1'($urandom);
      f4.out_ready = ($urandom_range(0, 3) != 0);
      f16.in_valid = ($urandom_range(0, 3) != 0);
      f16.a = 16'($urandom); f16.b = 16'($urandom); f16.bin = 1'($urandom);
      f16.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      finish_cycle();
    end
    chk("rand_count_w4", n_out[0] >= 10000, 1);
    chk("rand_count_w16", n_out[1] >= 10000, 1);

    f4.in_valid = 1'b0; f4.out_ready = 1'b1;
    f16.in_valid = 1'b0; f16.out_ready = 1'b1;
    for (int c = 0; c < 20 && (q4.size() != 0 || q16.size() != 0); c++) begin
      @(negedge clk);
      finish_cycle();
    end
    chk("drain_w4", q4.size(), 0);
    chk("drain_w16", q16.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
